uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_ctrl_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and defaults for the UART transmit scheduler.
//   state_e            : scheduler FSM states
//   *_DEF              : default parameter values
//   max_int / cnt_w    : helpers for sizing the shared cycle counter
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_e;

   localparam int NREQ_DEF           = 4;
   localparam int DBIT_DEF           = 8;
   localparam int GAP_CYCLES_DEF     = 16;
   localparam int TIMEOUT_CYCLES_DEF = 2_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width that holds every value 0..n (at least 1 bit).
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: first set bit of req found when
// searching upward from ptr, wrapping NREQ-1 -> 0.
//   req          in  NREQ  request vector
//   ptr          in  IW    search start index
//   grant_onehot out NREQ  one-hot winner (zero when no request)
//   grant_idx    out IW    winner index (0 when no request)
//   any_grant    out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IW-1:0]   grant_idx,
   output logic            any_grant
);

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any_grant    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         // Once a winner is found later candidates are masked off.
         if (!any_grant && req[(int'(ptr) + i) % NREQ]) begin
            any_grant                                = 1'b1;
            grant_idx                                = IW'((int'(ptr) + i) % NREQ);
            grant_onehot[(int'(ptr) + i) % NREQ]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NREQ byte requesters. In IDLE a
// round-robin winner is accepted (req_ready strobe), its byte is latched and
// launched with a one-cycle tx_start, then the block waits for tx_done (or a
// timeout) and idles GAP_CYCLES cycles before arbitrating again.
//   clk, rst_n   clock / async active-low reset
//   req_valid    in  NREQ       per-requester byte available
//   req_data     in  NREQ*DBIT  requester i at [i*DBIT +: DBIT]
//   req_ready    out NREQ       accept strobe (combinational, IDLE only)
//   tx_start     out 1          start pulse to transmitter
//   tx_data      out DBIT       latched byte
//   tx_done      in  1          completion pulse from transmitter
//   busy         out 1          state != IDLE
//   grant_id     out IW         requester currently / last served
//   timeout_err  out 1          pulse when tx_done never arrived
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter  int NREQ           = NREQ_DEF,
   parameter  int DBIT           = DBIT_DEF,
   parameter  int GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int IW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DBIT-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic [IW-1:0]        grant_id,
   output logic                 timeout_err
);

   // One counter serves both WAIT_DONE (timeout) and GAP; it is cleared on
   // every state entry so it never needs more than max(...) values.
   localparam int CW = cnt_w(max_int(GAP_CYCLES, TIMEOUT_CYCLES));
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [DBIT-1:0]   data_q, data_d;
   logic [IW-1:0]     gid_q, gid_d;
   logic              terr_q, terr_d;

   logic [NREQ-1:0]   gnt_oh;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req          (req_valid),
      .ptr          (ptr_q),
      .grant_onehot (gnt_oh),
      .grant_idx    (gnt_idx),
      .any_grant    (gnt_any)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      gid_d     = gid_q;
      terr_d    = 1'b0;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               req_ready = gnt_oh;
               data_d    = req_data[int'(gnt_idx)*DBIT +: DBIT];
               gid_d     = gnt_idx;
               // Explicit wrap so non-power-of-two NREQ works.
               ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
               state_d   = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done || cnt_q == TO_LAST) begin
               // tx_done takes priority over a coincident timeout.
               terr_d  = !tx_done;
               cnt_d   = '0;
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         gid_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         terr_q  <= terr_d;
      end
   end

   assign tx_start    = (state_q == START);
   assign busy        = (state_q != IDLE);
   assign tx_data     = data_q;
   assign grant_id    = gid_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench: NREQ=4, DBIT=8, GAP_CYCLES=4, TIMEOUT_CYCLES=20.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 3
// units after it (before the falling edge).
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   localparam int NREQ = 4;
   localparam int DBIT = 8;
   localparam int GAPC = 4;
   localparam int TOC  = 20;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DBIT-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 tx_start;
   logic [DBIT-1:0]      tx_data;
   logic                 tx_done;
   logic                 busy;
   logic [1:0]           grant_id;
   logic                 timeout_err;

   int checks   = 0;
   int failures = 0;

   uart_tx_scheduler #(
      .NREQ(NREQ), .DBIT(DBIT), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TOC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] exp_ready;
      logic [1:0] exp_gid;
      int         dly;
   } vec_t;

   vec_t tbl[12];

   localparam int M_DONE  = 0;  // tx_done after dly WAIT_DONE cycles
   localparam int M_TO    = 1;  // tx_done never arrives
   localparam int M_SIMUL = 2;  // tx_done on the timeout cycle
   localparam int M_RST   = 3;  // reset in WAIT_DONE

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk("idle_wait", 32'(busy), 32'(0));
   endtask

   task automatic run_txn(input logic [3:0] v, input logic [3:0] er,
                          input logic [1:0] g, input logic [7:0] d,
                          input int mode, input int dly);
      wait_idle();
      req_valid = v;
      #2;
      chk("req_ready", 32'(req_ready), 32'(er));
      tick();
      req_valid = '0;
      #2;
      chk("tx_start", 32'(tx_start), 32'(1));
      chk("tx_data", 32'(tx_data), 32'(d));
      chk("grant_id", 32'(grant_id), 32'(g));
      chk("ready_start", 32'(req_ready), 32'(0));
      tick();
      #2;
      chk("start_one_cycle", 32'(tx_start), 32'(0));
      // now in WAIT_DONE, entry cycle k=0
      if (mode == M_RST) begin
         repeat (3) tick();
         rst_n = 1'b0;
         #1;
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_tx_start", 32'(tx_start), 32'(0));
         chk("rst_tx_data", 32'(tx_data), 32'(0));
         chk("rst_grant_id", 32'(grant_id), 32'(0));
         chk("rst_timeout_err", 32'(timeout_err), 32'(0));
         chk("rst_ready", 32'(req_ready), 32'(0));
         tick();
         tick();
         rst_n = 1'b1;
         return;
      end
      if (mode == M_DONE) begin
         repeat (dly) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         #2;
         chk("no_timeout", 32'(timeout_err), 32'(0));
      end else if (mode == M_TO) begin
         for (int k = 0; k < TOC; k++) begin
            chk("to_early", 32'(timeout_err), 32'(0));
            tick();
            #2;
         end
         chk("to_pulse", 32'(timeout_err), 32'(1));
      end else begin
         repeat (TOC - 1) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         #2;
         chk("simul_no_to", 32'(timeout_err), 32'(0));
      end
      // GAP lasts exactly GAPC cycles
      for (int gg = 0; gg < GAPC; gg++) begin
         chk("gap_busy", 32'(busy), 32'(1));
         if (gg > 0) chk("to_one_cycle", 32'(timeout_err), 32'(0));
         chk("gap_ready", 32'(req_ready), 32'(0));
         tick();
         #2;
      end
      chk("gap_len", 32'(busy), 32'(0));
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 3};
      tbl[1]  = '{4'b1111, 4'b0010, 2'd1, 0};
      tbl[2]  = '{4'b1111, 4'b0100, 2'd2, 5};
      tbl[3]  = '{4'b1111, 4'b1000, 2'd3, 1};
      tbl[4]  = '{4'b1111, 4'b0001, 2'd0, 2};
      tbl[5]  = '{4'b0101, 4'b0100, 2'd2, 0};
      tbl[6]  = '{4'b1001, 4'b1000, 2'd3, 4};
      tbl[7]  = '{4'b1001, 4'b0001, 2'd0, 1};
      tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 0};
      tbl[9]  = '{4'b0001, 4'b0001, 2'd0, 2};
      tbl[10] = '{4'b1100, 4'b0100, 2'd2, 0};
      tbl[11] = '{4'b0110, 4'b0010, 2'd1, 1};

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      tx_done   = 1'b0;
      tick();
      tick();
      #1;
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_tx_start", 32'(tx_start), 32'(0));
      chk("reset_tx_data", 32'(tx_data), 32'(0));
      chk("reset_grant_id", 32'(grant_id), 32'(0));
      chk("reset_timeout_err", 32'(timeout_err), 32'(0));
      chk("reset_ready", 32'(req_ready), 32'(0));
      rst_n = 1'b1;
      tick();

      // arbitration table: contention, wrap-around, no request
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].valid == 4'b0000) begin
            wait_idle();
            req_valid = '0;
            #2;
            chk("none_ready", 32'(req_ready), 32'(0));
            tick();
            #2;
            chk("none_busy", 32'(busy), 32'(0));
            chk("none_start", 32'(tx_start), 32'(0));
         end else begin
            run_txn(tbl[i].valid, tbl[i].exp_ready, tbl[i].exp_gid,
                    8'hA0 + 8'(tbl[i].exp_gid), M_DONE, tbl[i].dly);
         end
      end

      // single request, byte 0x41, tx_done 10 cycles into WAIT_DONE (ptr 2 -> 1)
      req_data[7:0] = 8'h41;
      run_txn(4'b0001, 4'b0001, 2'd0, 8'h41, M_DONE, 10);
      req_data[7:0] = 8'hA0;

      // timeout on requester 1, then requester 2 is served normally
      run_txn(4'b1111, 4'b0010, 2'd1, 8'hA1, M_TO, 0);
      run_txn(4'b1111, 4'b0100, 2'd2, 8'hA2, M_DONE, 2);

      // tx_done coincides with the timeout cycle
      run_txn(4'b1111, 4'b1000, 2'd3, 8'hA3, M_SIMUL, 0);

      // stray tx_done in IDLE changes nothing (ptr stays 0)
      wait_idle();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      #2;
      chk("stray_busy", 32'(busy), 32'(0));
      chk("stray_start", 32'(tx_start), 32'(0));
      chk("stray_to", 32'(timeout_err), 32'(0));
      run_txn(4'b0011, 4'b0001, 2'd0, 8'hA0, M_DONE, 0);

      // reset mid WAIT_DONE, then arbitration restarts from requester 0
      run_txn(4'b1111, 4'b0010, 2'd1, 8'hA1, M_RST, 0);
      run_txn(4'b0100, 4'b0100, 2'd2, 8'hA2, M_DONE, 1);
      run_txn(4'b1111, 4'b1000, 2'd3, 8'hA3, M_DONE, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
